// File: rtl/io_bank_arbiter.sv
// rtl/io_bank_arbiter.sv - round-robin whole-bank IO pad arbiter with tri-state guard intervals
// A requester owns every pad while granted; pads are released for TURN_CYCLES before and after each grant.
module io_bank_arbiter #(
   parameter int NUM_IO      = 24,
   parameter int NUM_REQ     = 4,
   parameter int TURN_CYCLES = 2,
   parameter int MAX_HOLD    = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   input  logic [NUM_REQ*NUM_IO-1:0]  req_out,
   input  logic [NUM_REQ*NUM_IO-1:0]  req_oeb,
   output logic [NUM_IO-1:0]          req_in,
   input  logic [NUM_IO-1:0]          io_in,
   output logic [NUM_IO-1:0]          io_out,
   output logic [NUM_IO-1:0]          io_oeb,
   output logic                       busy,
   output logic                       timeout_evt
);

   localparam int PW      = $clog2(NUM_REQ);
   localparam int CNT_MAX = (MAX_HOLD > TURN_CYCLES) ? MAX_HOLD : TURN_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [CW-1:0] HOLD_SAT  = CW'(MAX_HOLD);

   typedef enum logic [1:0] {IDLE, TURN, GRANT, PARK} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_IO-1:0]   io_out_q, io_out_d;
   logic [NUM_IO-1:0]   io_oeb_q, io_oeb_d;
   logic [NUM_IO-1:0]   req_in_q, req_in_d;
   logic                timeout_evt_q, timeout_evt_d;

   logic [PW-1:0]       pick;
   logic                pick_vld;
   logic [PW-1:0]       next_ptr;
   logic [NUM_REQ-1:0]  other_req;
   logic                hold_expired;

   // Scan offsets high to low so the requester closest to ptr is the last (winning) write.
   always_comb begin
      int idx;
      idx      = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[idx]) begin
            pick     = PW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      next_ptr           = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      other_req          = req;
      other_req[owner_q] = 1'b0;
      hold_expired       = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST) && (|other_req);
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      gnt_d         = gnt_q;
      io_out_d      = '0;
      io_oeb_d      = '1;
      req_in_d      = io_in;
      timeout_evt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d = pick;
               cnt_d   = '0;
               state_d = TURN;
            end
         end
         TURN: begin
            if (!req[owner_q]) begin
               ptr_d   = next_ptr;
               state_d = IDLE;
            end else if (cnt_q == TURN_LAST) begin
               gnt_d          = '0;
               gnt_d[owner_q] = 1'b1;
               cnt_d          = '0;
               state_d        = GRANT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GRANT: begin
            // A voluntary release wins over a timeout in the same cycle, so no event is flagged.
            if (!req[owner_q] || hold_expired) begin
               timeout_evt_d = req[owner_q];
               gnt_d         = '0;
               ptr_d         = next_ptr;
               cnt_d         = '0;
               state_d       = PARK;
            end else begin
               io_out_d = req_out[int'(owner_q)*NUM_IO +: NUM_IO];
               io_oeb_d = req_oeb[int'(owner_q)*NUM_IO +: NUM_IO];
               if (cnt_q != HOLD_SAT) cnt_d = cnt_q + 1'b1;
            end
         end
         PARK: begin
            if (cnt_q == TURN_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         cnt_q         <= '0;
         gnt_q         <= '0;
         io_out_q      <= '0;
         io_oeb_q      <= '1;
         req_in_q      <= '0;
         timeout_evt_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         gnt_q         <= gnt_d;
         io_out_q      <= io_out_d;
         io_oeb_q      <= io_oeb_d;
         req_in_q      <= req_in_d;
         timeout_evt_q <= timeout_evt_d;
      end
   end

   assign gnt         = gnt_q;
   assign io_out      = io_out_q;
   assign io_oeb      = io_oeb_q;
   assign req_in      = req_in_q;
   assign timeout_evt = timeout_evt_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_io_bank_arbiter.sv
// tb/tb_io_bank_arbiter.sv - self-checking bench for io_bank_arbiter
// Constant vector table, hand sequences for round-robin and timeout, random stimulus vs a reference model.
module tb_io_bank_arbiter;
   localparam int NIO = 24;
   localparam int NRQ = 4;
   localparam int TC  = 2;
   localparam int MH  = 8;
   localparam logic [NIO-1:0] ALL1 = '1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NRQ-1:0]  req;
   logic [NRQ-1:0]  gnt;
   logic [NRQ*NIO-1:0] req_out, req_oeb;
   logic [NIO-1:0]  req_in, io_in, io_out, io_oeb;
   logic            busy, timeout_evt;

   always #5 clk = ~clk;

   io_bank_arbiter #(.NUM_IO(NIO), .NUM_REQ(NRQ), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .req_out(req_out), .req_oeb(req_oeb),
      .req_in(req_in), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .busy(busy),
      .timeout_evt(timeout_evt)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: owner (-1 = none), remaining guard cycles, hold length.
   int m_owner = -1, m_ptr = 0, m_wait = 0, m_park = 0, m_hold = 0;
   bit m_granted = 0;
   logic [NRQ-1:0] e_gnt = '0;
   logic [NIO-1:0] e_out = '0, e_oeb = '1, e_in = '0;
   logic           e_to = 1'b0;

   always @(posedge clk) begin : model
      logic [NRQ-1:0] others;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_wait = 0; m_park = 0; m_hold = 0; m_granted = 0;
         e_gnt = '0; e_out = '0; e_oeb = '1; e_in = '0; e_to = 1'b0;
      end else begin
         e_in = io_in;
         e_to = 1'b0;
         if (m_granted) begin
            others = req & ~(4'(1) << m_owner);
            if (!req[m_owner] || (MH != 0 && m_hold == MH - 1 && others != 0)) begin
               e_to = req[m_owner];
               m_ptr = (m_owner + 1) % NRQ;
               m_owner = -1; m_granted = 0; m_park = TC;
               e_gnt = '0; e_out = '0; e_oeb = '1;
            end else begin
               e_out = req_out[m_owner*NIO +: NIO];
               e_oeb = req_oeb[m_owner*NIO +: NIO];
               if (m_hold < MH) m_hold++;
            end
         end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_ptr = (m_owner + 1) % NRQ;
               m_owner = -1;
            end else begin
               m_wait--;
               if (m_wait == 0) begin
                  m_granted = 1; m_hold = 0; e_gnt = 4'(1) << m_owner;
               end
            end
         end else if (m_park > 0) begin
            m_park--;
         end else if (req != 0) begin
            for (int k = 0; k < NRQ; k++) begin
               if (req[(m_ptr + k) % NRQ]) begin
                  m_owner = (m_ptr + k) % NRQ;
                  break;
               end
            end
            m_wait = TC;
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      logic e_busy;
      @(posedge clk);
      @(negedge clk);
      e_busy = (m_owner >= 0) || (m_park > 0);
      vectors++;
      if ({gnt, io_out, io_oeb, req_in, busy, timeout_evt} !== {e_gnt, e_out, e_oeb, e_in, e_busy, e_to}) begin
         miscompares++;
         $display("FAIL model @%0t: gnt %h/%h out %h/%h oeb %h/%h in %h/%h busy %b/%b to %b/%b (got/expected)",
                  $time, gnt, e_gnt, io_out, e_out, io_oeb, e_oeb, req_in, e_in, busy, e_busy, timeout_evt, e_to);
      end
   endtask

   typedef struct {
      logic           rst_n;
      logic [NRQ-1:0] req;
      logic [NRQ-1:0] gnt;
      logic           busy;
      logic [NIO-1:0] oeb;
      logic [NIO-1:0] out;
   } vec_t;

   function automatic vec_t mk(logic r, logic [NRQ-1:0] q, logic [NRQ-1:0] g, logic b,
                               logic [NIO-1:0] oe, logic [NIO-1:0] o);
      vec_t v;
      v.rst_n = r; v.req = q; v.gnt = g; v.busy = b; v.oeb = oe; v.out = o;
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      int n, gap, g, t, bad;
      logic [NIO-1:0] exp_in;

      tbl[0]  = mk(0, 4'b0100, 4'b0000, 0, ALL1, 24'h0);
      tbl[1]  = mk(1, 4'b0100, 4'b0000, 1, ALL1, 24'h0);
      tbl[2]  = mk(1, 4'b0100, 4'b0000, 1, ALL1, 24'h0);
      tbl[3]  = mk(1, 4'b0100, 4'b0100, 1, ALL1, 24'h0);
      tbl[4]  = mk(1, 4'b0100, 4'b0100, 1, 24'h0, 24'hA5A5A5);
      tbl[5]  = mk(1, 4'b0000, 4'b0000, 1, ALL1, 24'h0);
      tbl[6]  = mk(1, 4'b0000, 4'b0000, 1, ALL1, 24'h0);
      tbl[7]  = mk(1, 4'b0000, 4'b0000, 0, ALL1, 24'h0);
      tbl[8]  = mk(1, 4'b0000, 4'b0000, 0, ALL1, 24'h0);
      tbl[9]  = mk(1, 4'b0010, 4'b0000, 1, ALL1, 24'h0);
      tbl[10] = mk(1, 4'b0000, 4'b0000, 0, ALL1, 24'h0);
      tbl[11] = mk(1, 4'b0110, 4'b0000, 1, ALL1, 24'h0);
      tbl[12] = mk(1, 4'b0110, 4'b0000, 1, ALL1, 24'h0);
      tbl[13] = mk(1, 4'b0110, 4'b0100, 1, ALL1, 24'h0);
      tbl[14] = mk(1, 4'b0110, 4'b0100, 1, 24'h0, 24'hA5A5A5);
      tbl[15] = mk(0, 4'b0110, 4'b0000, 0, ALL1, 24'h0);

      rst_n   = 1'b0;
      req     = '0;
      io_in   = '0;
      req_out = {24'h333333, 24'hA5A5A5, 24'h111111, 24'h0F0F0F};
      req_oeb = '0;
      @(negedge clk);
      tick();
      tick();

      for (int i = 0; i < 16; i++) begin
         rst_n = tbl[i].rst_n;
         req   = tbl[i].req;
         io_in = 24'h123456 + 24'(i);
         exp_in = tbl[i].rst_n ? io_in : 24'h0;
         tick();
         check($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].gnt));
         check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
         check($sformatf("tbl%0d_oeb", i), 64'(io_oeb), 64'(tbl[i].oeb));
         check($sformatf("tbl%0d_out", i), 64'(io_out), 64'(tbl[i].out));
         check($sformatf("tbl%0d_req_in", i), 64'(req_in), 64'(exp_in));
         check($sformatf("tbl%0d_to", i), 64'(timeout_evt), 64'(0));
      end

      // Round-robin with every requester holding req except for a one-cycle release.
      rst_n = 1'b1;
      req   = 4'b1111;
      gap   = 0;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         while (gnt == 0 && n < 20) begin
            tick();
            n++;
            if (io_oeb == ALL1) gap++;
         end
         check($sformatf("rr%0d_gnt", k), 64'(gnt), 64'(4'(1) << (k % NRQ)));
         if (k > 0) check($sformatf("rr%0d_gap_ge4", k), 64'(gap >= 4), 64'(1));
         tick();
         check($sformatf("rr%0d_out", k), 64'(io_out), 64'(req_out[(k % NRQ)*NIO +: NIO]));
         repeat (3) tick();
         req[k % NRQ] = 1'b0;
         tick();
         check($sformatf("rr%0d_rel_oeb", k), 64'(io_oeb), 64'(ALL1));
         gap = (io_oeb == ALL1) ? 1 : 0;
         req = 4'b1111;
      end

      // Sole requester never times out.
      rst_n = 1'b0; req = 4'b0001; tick();
      rst_n = 1'b1;
      n = 0;
      while (gnt == 0 && n < 20) begin tick(); n++; end
      check("solo_gnt", 64'(gnt), 64'(4'b0001));
      bad = 0;
      repeat (30) begin
         tick();
         if (gnt != 4'b0001 || timeout_evt) bad++;
      end
      check("solo_keeps_bank", 64'(bad), 64'(0));

      // Forced release after MAX_HOLD grant cycles once requester 1 waits.
      rst_n = 1'b0; tick();
      rst_n = 1'b1;
      n = 0;
      while (gnt == 0 && n < 20) begin tick(); n++; end
      check("to_gnt0", 64'(gnt), 64'(4'b0001));
      req = 4'b0011;
      g = 1; t = 0; n = 0;
      while (gnt == 4'b0001 && n < 40) begin
         tick();
         n++;
         if (gnt == 4'b0001) g++;
         if (timeout_evt) t++;
      end
      check("to_hold_cycles", 64'(g), 64'(MH));
      n = 0;
      while (gnt == 0 && n < 20) begin
         tick();
         n++;
         if (timeout_evt) t++;
      end
      check("to_gnt1", 64'(gnt), 64'(4'b0010));
      check("to_gnt1_latency", 64'(n), 64'(2*TC + 1));
      check("to_evt_count", 64'(t), 64'(1));

      // Random stimulus against the reference model.
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int b = 0; b < NRQ; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         req_out = {$urandom(), $urandom(), $urandom()};
         req_oeb = {$urandom(), $urandom(), $urandom()};
         io_in   = 24'($urandom());
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
